// File: rtl/chunk_packetizer.sv
// Chunk packetizer: waits until the upstream FIFO holds a full chunk, emits a
// header word carrying the running word address, then streams exactly CHUNK
// payload words straight through from the FIFO to the downstream port.
module chunk_packetizer #(
  parameter int WIDTH      = 8,
  parameter int CHUNK      = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  sysClk,
  input  logic                  reset,
  input  logic                  cfgEnable,
  input  logic [ADDR_WIDTH-1:0] cfgBase,
  input  logic [WIDTH-1:0]      iData,
  input  logic                  iValid,
  input  logic                  iValidChunk,
  output logic                  iReady,
  output logic [WIDTH-1:0]      oData,
  output logic                  oSop,
  output logic                  oEop,
  output logic                  oValid,
  input  logic                  oReady,
  output logic [15:0]           pktCount
);

  localparam int BEAT_W = $clog2(CHUNK);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(CHUNK - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(CHUNK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [15:0]             pktCount_q, pktCount_d;
  logic                    lastBeat;

  assign lastBeat = (beat_q == LAST_BEAT);
  assign pktCount = pktCount_q;

  // Next-state logic: a payload beat only advances when a word actually moves
  // from upstream to downstream, so stalls on either side freeze everything.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    pktCount_d = pktCount_q;
    case (state_q)
      S_IDLE: begin
        if (cfgEnable && iValidChunk) begin
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (oReady) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end
      S_DATA: begin
        if (iValid && oReady) begin
          if (lastBeat) begin
            state_d    = S_IDLE;
            beat_d     = '0;
            addr_d     = addr_q + ADDR_STEP;
            pktCount_d = pktCount_q + 16'd1;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // State register; reset abandons any packet and reloads the base address.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= cfgBase;
      beat_q     <= '0;
      pktCount_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      pktCount_q <= pktCount_d;
    end
  end

  // Output decode: header comes from the address register, payload is a
  // combinational pass-through so no extra buffering is needed.
  always_comb begin
    oValid = 1'b0;
    oSop   = 1'b0;
    oEop   = 1'b0;
    oData  = '0;
    iReady = 1'b0;
    case (state_q)
      S_HDR: begin
        oValid = 1'b1;
        oSop   = 1'b1;
        oData  = WIDTH'(addr_q);
      end
      S_DATA: begin
        oValid = iValid;
        oData  = iData;
        oEop   = lastBeat;
        iReady = oReady;
      end
      default: begin
        oValid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_chunk_packetizer.sv
// Testbench for chunk_packetizer: models the upstream FIFO as a queue and
// predicts the downstream word stream from the packet format alone.
module tb_chunk_packetizer;

  localparam int CHUNK = 4;

  logic        sysClk;
  logic        reset;
  logic        cfgEnable;
  logic [7:0]  cfgBase;
  logic [7:0]  iData;
  logic        iValid;
  logic        iValidChunk;
  logic        iReady;
  logic [7:0]  oData;
  logic        oSop;
  logic        oEop;
  logic        oValid;
  logic        oReady;
  logic [15:0] pktCount;

  int checks = 0;
  int errors = 0;

  // Upstream FIFO contents, all words loaded this test, observed and expected
  // downstream transfers packed as {sop, eop, data}.
  logic [7:0] upq[$];
  logic [7:0] srcWords[$];
  logic [9:0] obs[$];
  logic [9:0] expq[$];
  int         obsCyc[$];

  int         cyc;
  int         holdViol;
  int         readyViol;
  bit         prevHdrStall;
  logic [7:0] prevHdrData;
  bit         stallMode;
  bit         validGate;
  bit         readyGate;

  chunk_packetizer #(.WIDTH(8), .CHUNK(CHUNK), .ADDR_WIDTH(8)) dut (
    .sysClk      (sysClk),
    .reset       (reset),
    .cfgEnable   (cfgEnable),
    .cfgBase     (cfgBase),
    .iData       (iData),
    .iValid      (iValid),
    .iValidChunk (iValidChunk),
    .iReady      (iReady),
    .oData       (oData),
    .oSop        (oSop),
    .oEop        (oEop),
    .oValid      (oValid),
    .oReady      (oReady),
    .pktCount    (pktCount)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  // One clock: drive inputs after the falling edge, observe, then advance.
  task automatic step();
    if (stallMode) begin
      validGate = 1'($urandom_range(0, 1));
      readyGate = 1'($urandom_range(0, 1));
    end
    if (upq.size() > 0) iData = upq[0];
    else iData = 8'($urandom);
    iValid      = (upq.size() > 0) && validGate;
    iValidChunk = (upq.size() >= CHUNK);
    oReady      = readyGate;
    #1;
    if (prevHdrStall && (!oValid || !oSop || oData !== prevHdrData)) holdViol++;
    prevHdrStall = oValid && oSop && !oReady;
    prevHdrData  = oData;
    if (iReady && (oSop || (iValid && !oValid))) readyViol++;
    if (oValid && oReady) begin
      obs.push_back({oSop, oEop, oData});
      obsCyc.push_back(cyc);
    end
    if (iValid && iReady) void'(upq.pop_front());
    cyc++;
    @(posedge sysClk);
    @(negedge sysClk);
  endtask

  task automatic runUntil(input int n, input int budget, output bit timedOut);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      step();
      k++;
    end
    timedOut = (obs.size() < n);
  endtask

  task automatic doReset(input logic [7:0] base);
    cfgBase   = base;
    reset     = 1'b1;
    stallMode = 1'b0;
    validGate = 1'b1;
    readyGate = 1'b1;
    upq.delete();
    srcWords.delete();
    obs.delete();
    obsCyc.delete();
    holdViol     = 0;
    readyViol    = 0;
    prevHdrStall = 1'b0;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic loadWords(input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      upq.push_back(w);
      srcWords.push_back(w);
    end
  endtask

  // Reference stream: header = base + packet*CHUNK (mod 256), then the next
  // CHUNK upstream words in FIFO order, eop on the last of them.
  task automatic buildExpected(input logic [7:0] base, input int nPk);
    expq.delete();
    for (int p = 0; p < nPk; p++) begin
      expq.push_back({1'b1, 1'b0, 8'(int'(base) + p * CHUNK)});
      for (int i = 0; i < CHUNK; i++)
        expq.push_back({1'b0, (i == CHUNK - 1), srcWords[p * CHUNK + i]});
    end
  endtask

  task automatic test_reset();
    doReset(8'h10);
    loadWords(CHUNK);
    cfgEnable = 1'b1;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({oValid, iReady, oSop, oEop} !== 4'b0) begin
        errors++;
        $display("FAIL reset_ctrl: got %b expected 0000", {oValid, iReady, oSop, oEop});
      end
      checks++;
      if (oData !== 8'h00) begin
        errors++;
        $display("FAIL reset_data: got %h expected 00", oData);
      end
      checks++;
      if (pktCount !== 16'd0) begin
        errors++;
        $display("FAIL reset_count: got %0d expected 0", pktCount);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit to;
    doReset(8'h40);
    upq = '{8'h94, 8'h5D, 8'hFD, 8'h4F};
    srcWords = upq;
    cfgEnable = 1'b1;
    runUntil(CHUNK + 1, 40, to);
    step();
    step();
    buildExpected(8'h40, 1);
    checks++;
    if (to || obs.size() != expq.size()) begin
      errors++;
      $display("FAIL single_len: got %0d words expected %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        errors++;
        $display("FAIL single_word%0d: got %h expected %h", i,
                 (i < obs.size()) ? obs[i] : 10'h3FF, expq[i]);
      end
    end
    checks++;
    if (pktCount !== 16'd1) begin
      errors++;
      $display("FAIL single_count: got %0d expected 1", pktCount);
    end
    loadWords(CHUNK);
    runUntil(CHUNK + 2, 40, to);
    checks++;
    if (to || obs[CHUNK + 1] !== {2'b10, 8'h44}) begin
      errors++;
      $display("FAIL single_nextaddr: got %h expected %h", (to ? 10'h3FF : obs[CHUNK + 1]), {2'b10, 8'h44});
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    doReset(8'h40);
    loadWords(2 * CHUNK);
    cfgEnable = 1'b1;
    runUntil(2 * (CHUNK + 1), 60, to);
    step();
    step();
    buildExpected(8'h40, 2);
    checks++;
    if (to || obs.size() != expq.size()) begin
      errors++;
      $display("FAIL b2b_len: got %0d words expected %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h expected %h", i,
                 (i < obs.size()) ? obs[i] : 10'h3FF, expq[i]);
      end
    end
    checks++;
    if (obsCyc.size() < CHUNK + 2 || obsCyc[CHUNK + 1] - obsCyc[CHUNK] != 2) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles expected 2",
               (obsCyc.size() < CHUNK + 2) ? -1 : obsCyc[CHUNK + 1] - obsCyc[CHUNK]);
    end
    checks++;
    if (pktCount !== 16'd2) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 2", pktCount);
    end
  endtask

  task automatic test_stalls();
    bit to;
    logic [7:0] base;
    base = 8'($urandom);
    doReset(base);
    loadWords(5 * CHUNK);
    cfgEnable = 1'b1;
    stallMode = 1'b1;
    runUntil(5 * (CHUNK + 1), 600, to);
    stallMode = 1'b0;
    validGate = 1'b1;
    readyGate = 1'b1;
    step();
    step();
    buildExpected(base, 5);
    checks++;
    if (to || obs.size() != expq.size()) begin
      errors++;
      $display("FAIL stall_len: got %0d words expected %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        errors++;
        $display("FAIL stall_word%0d: got %h expected %h", i,
                 (i < obs.size()) ? obs[i] : 10'h3FF, expq[i]);
      end
    end
    checks++;
    if (holdViol != 0 || readyViol != 0) begin
      errors++;
      $display("FAIL stall_hold: got hold=%0d ready=%0d expected 0 0", holdViol, readyViol);
    end
    checks++;
    if (pktCount !== 16'd5) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 5", pktCount);
    end
  endtask

  task automatic test_wrap();
    bit to;
    doReset(8'hFC);
    loadWords(3 * CHUNK);
    cfgEnable = 1'b1;
    runUntil(3 * (CHUNK + 1), 100, to);
    buildExpected(8'hFC, 3);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL wrap_len: got %0d words expected %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        errors++;
        $display("FAIL wrap_word%0d: got %h expected %h", i,
                 (i < obs.size()) ? obs[i] : 10'h3FF, expq[i]);
      end
    end
    checks++;
    if (pktCount !== 16'd3) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected 3", pktCount);
    end
  endtask

  task automatic test_enable_drop();
    bit to;
    doReset(8'h80);
    loadWords(2 * CHUNK);
    cfgEnable = 1'b1;
    runUntil(1, 20, to);
    cfgEnable = 1'b0;
    repeat (30) step();
    buildExpected(8'h80, 1);
    checks++;
    if (to || obs.size() != expq.size()) begin
      errors++;
      $display("FAIL endrop_len: got %0d words expected %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        errors++;
        $display("FAIL endrop_word%0d: got %h expected %h", i,
                 (i < obs.size()) ? obs[i] : 10'h3FF, expq[i]);
      end
    end
    checks++;
    if (pktCount !== 16'd1 || upq.size() != CHUNK) begin
      errors++;
      $display("FAIL endrop_count: got pkt=%0d left=%0d expected 1 %0d", pktCount, upq.size(), CHUNK);
    end
    cfgEnable = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit to;
    doReset(8'h20);
    loadWords(2 * CHUNK);
    cfgEnable = 1'b1;
    runUntil(CHUNK + 1 + 3, 60, to);
    checks++;
    if (to || pktCount !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_pre: got pkt=%0d expected 1", pktCount);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({oValid, iReady, oSop, oEop} !== 4'b0 || oData !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_out: got ctrl=%b data=%h expected 0000 00", {oValid, iReady, oSop, oEop}, oData);
    end
    checks++;
    if (pktCount !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_count: got %0d expected 0", pktCount);
    end
    @(negedge sysClk);
    doReset(8'h30);
    loadWords(CHUNK);
    runUntil(CHUNK + 1, 40, to);
    buildExpected(8'h30, 1);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL rstmid_len: got %0d words expected %0d", obs.size(), expq.size());
    end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= obs.size() || obs[i] !== expq[i]) begin
        errors++;
        $display("FAIL rstmid_word%0d: got %h expected %h", i,
                 (i < obs.size()) ? obs[i] : 10'h3FF, expq[i]);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    cfgEnable   = 1'b0;
    cfgBase     = 8'h00;
    iData       = 8'h00;
    iValid      = 1'b0;
    iValidChunk = 1'b0;
    oReady      = 1'b0;
    @(negedge sysClk);
    test_reset();
    test_single();
    test_back_to_back();
    test_stalls();
    test_wrap();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
